// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM micro-op sequencer: instruction field map,
// opcode, sequencer states and pipeline depth.
package gemm_pkg;

    localparam int PIPE_DEPTH = 4;

    localparam logic [2:0] OPCODE_GEMM = 3'b010;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 2;
    localparam int RST_BIT  = 7;
    localparam int UBGN_LSB = 8;
    localparam int UBGN_MSB = 20;
    localparam int UEND_LSB = 21;
    localparam int UEND_MSB = 34;
    localparam int IOUT_LSB = 35;
    localparam int IOUT_MSB = 48;
    localparam int IIN_LSB  = 49;
    localparam int IIN_MSB  = 62;
    localparam int DFO_LSB  = 63;
    localparam int DFO_MSB  = 73;
    localparam int DFI_LSB  = 74;
    localparam int DFI_MSB  = 84;
    localparam int SFO_LSB  = 85;
    localparam int SFO_MSB  = 95;
    localparam int SFI_LSB  = 96;
    localparam int SFI_MSB  = 106;
    localparam int WFO_LSB  = 107;
    localparam int WFO_MSB  = 116;
    localparam int WFI_LSB  = 117;
    localparam int WFI_MSB  = 126;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gemm_loop_ctr.sv
// One loop level of the GEMM nest: iteration counter with wrap detect and
// dst/src/wgt offset accumulators stepping by a per-instruction factor.
module gemm_loop_ctr #(
    parameter int CW = 14,
    parameter int AW = 11,
    parameter int SW = 11,
    parameter int WW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic [CW-1:0] limit,
    input  logic [AW-1:0] dst_factor,
    input  logic [SW-1:0] src_factor,
    input  logic [WW-1:0] wgt_factor,
    output logic          wrap,
    output logic [AW-1:0] dst_offset,
    output logic [SW-1:0] src_offset,
    output logic [WW-1:0] wgt_offset
);

    logic [CW-1:0] count;

    assign wrap = (count == limit - CW'(1));

    // Offsets are running sums (i*factor), truncated to their own width.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count      <= '0;
            dst_offset <= '0;
            src_offset <= '0;
            wgt_offset <= '0;
        end else if (step) begin
            if (wrap) begin
                count      <= '0;
                dst_offset <= '0;
                src_offset <= '0;
                wgt_offset <= '0;
            end else begin
                count      <= count + CW'(1);
                dst_offset <= dst_offset + dst_factor;
                src_offset <= src_offset + src_factor;
                wgt_offset <= wgt_offset + wgt_factor;
            end
        end
    end

endmodule

// File: rtl/gemm_seq.sv
// GEMM micro-op loop sequencer: accepts one instruction, walks the
// outer/inner/uop nest one issue per unstalled cycle, drains, pulses done.
module gemm_seq
    import gemm_pkg::*;
#(
    parameter int INS_WIDTH     = 128,
    parameter int UPC_WIDTH     = 13,
    parameter int ITER_WIDTH    = 14,
    parameter int ACC_IDX_WIDTH = 12,
    parameter int INP_IDX_WIDTH = 12,
    parameter int WGT_IDX_WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INS_WIDTH-1:0]     insn,
    input  logic                     insn_valid,
    output logic                     insn_ready,
    input  logic                     stall,
    output logic                     issue_valid,
    output logic                     issue_reset,
    output logic [UPC_WIDTH-1:0]     upc,
    output logic [ACC_IDX_WIDTH-2:0] dst_offset_out,
    output logic [ACC_IDX_WIDTH-2:0] dst_offset_in,
    output logic [INP_IDX_WIDTH-2:0] src_offset_out,
    output logic [INP_IDX_WIDTH-2:0] src_offset_in,
    output logic [WGT_IDX_WIDTH-2:0] wgt_offset_out,
    output logic [WGT_IDX_WIDTH-2:0] wgt_offset_in,
    output logic                     busy,
    output logic                     done,
    output state_t                   fsm_state
);

    localparam int AW     = ACC_IDX_WIDTH - 1;
    localparam int SW     = INP_IDX_WIDTH - 1;
    localparam int WW     = WGT_IDX_WIDTH - 1;
    localparam int UEND_W = UEND_MSB - UEND_LSB + 1;
    localparam logic [2:0] DRAIN_LAST = 3'(PIPE_DEPTH - 1);

    // Handshake: an instruction transfers on a rising edge where insn_valid
    // and insn_ready are both high; insn_ready is high only while IDLE and
    // out of reset, and insn is not looked at in any other cycle.

    state_t              state;
    logic [2:0]          drain_cnt;
    logic [UEND_W-1:0]   u_cnt;
    logic [UEND_W-1:0]   end_r;
    logic [UPC_WIDTH-1:0] bgn_r;
    logic [ITER_WIDTH-1:0] iter_out_r, iter_in_r;
    logic [AW-1:0]       dfo_r, dfi_r;
    logic [SW-1:0]       sfo_r, sfi_r;
    logic [WW-1:0]       wfo_r, wfi_r;

    logic [2:0]            f_op;
    logic [UPC_WIDTH-1:0]  f_bgn;
    logic [UEND_W-1:0]     f_end;
    logic [ITER_WIDTH-1:0] f_iter_out, f_iter_in;

    assign f_op       = insn[OP_MSB:OP_LSB];
    assign f_bgn      = insn[UBGN_MSB:UBGN_LSB];
    assign f_end      = insn[UEND_MSB:UEND_LSB];
    assign f_iter_out = insn[IOUT_MSB:IOUT_LSB];
    assign f_iter_in  = insn[IIN_MSB:IIN_LSB];

    logic accept, degenerate, start, adv, u_wrap, in_wrap, out_wrap, last;
    logic step_in, step_out;

    assign insn_ready = (state == ST_IDLE) && !rst;
    assign accept     = insn_valid && insn_ready;
    assign degenerate = (f_op != OPCODE_GEMM) || (f_iter_out == '0) ||
                        (f_iter_in == '0) || (f_end <= UEND_W'(f_bgn));
    assign start      = accept && !degenerate;

    assign adv      = (state == ST_RUN) && !stall;
    assign u_wrap   = (u_cnt == end_r - UEND_W'(1));
    assign last     = u_wrap && in_wrap && out_wrap;
    // The final issue leaves every counter in place so outputs hold afterwards.
    assign step_in  = adv && u_wrap && !last;
    assign step_out = step_in && in_wrap;

    gemm_loop_ctr #(.CW(ITER_WIDTH), .AW(AW), .SW(SW), .WW(WW)) u_inner (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .step       (step_in),
        .limit      (iter_in_r),
        .dst_factor (dfi_r),
        .src_factor (sfi_r),
        .wgt_factor (wfi_r),
        .wrap       (in_wrap),
        .dst_offset (dst_offset_in),
        .src_offset (src_offset_in),
        .wgt_offset (wgt_offset_in)
    );

    gemm_loop_ctr #(.CW(ITER_WIDTH), .AW(AW), .SW(SW), .WW(WW)) u_outer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .step       (step_out),
        .limit      (iter_out_r),
        .dst_factor (dfo_r),
        .src_factor (sfo_r),
        .wgt_factor (wfo_r),
        .wrap       (out_wrap),
        .dst_offset (dst_offset_out),
        .src_offset (src_offset_out),
        .wgt_offset (wgt_offset_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            u_cnt       <= '0;
            end_r       <= '0;
            bgn_r       <= '0;
            iter_out_r  <= '0;
            iter_in_r   <= '0;
            dfo_r       <= '0;
            dfi_r       <= '0;
            sfo_r       <= '0;
            sfi_r       <= '0;
            wfo_r       <= '0;
            wfi_r       <= '0;
            issue_reset <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        issue_reset <= insn[RST_BIT];
                        bgn_r       <= f_bgn;
                        end_r       <= f_end;
                        iter_out_r  <= f_iter_out;
                        iter_in_r   <= f_iter_in;
                        dfo_r       <= insn[DFO_MSB:DFO_LSB];
                        dfi_r       <= insn[DFI_MSB:DFI_LSB];
                        sfo_r       <= insn[SFO_MSB:SFO_LSB];
                        sfi_r       <= insn[SFI_MSB:SFI_LSB];
                        wfo_r       <= insn[WFO_MSB:WFO_LSB];
                        wfi_r       <= insn[WFI_MSB:WFI_LSB];
                        if (degenerate) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                            u_cnt <= UEND_W'(f_bgn);
                        end
                    end
                end
                ST_RUN: begin
                    if (adv) begin
                        if (last) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end else if (u_wrap) begin
                            u_cnt <= UEND_W'(bgn_r);
                        end else begin
                            u_cnt <= u_cnt + UEND_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign issue_valid = (state == ST_RUN) && !stall && !rst;
    assign upc         = u_cnt[UPC_WIDTH-1:0];
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign fsm_state   = state;

    logic unused_bits;
    assign unused_bits = ^{insn[6:3], insn[INS_WIDTH-1], u_cnt[UEND_W-1]};

endmodule
